// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_MODE = 2'd1;
  localparam logic [1:0] CFG_CLR  = 2'd2;

  // Channel index width; a lone channel still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Interrupt lines, configuration port and core request/ack/EOI handshake.
interface intr_ctrl_if
  import intr_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned ID_W = id_width(NUM_CH);

  logic [NUM_CH-1:0] irq_in;
  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [NUM_CH-1:0] cfg_wdata;
  logic              cpu_irq;
  logic [ID_W-1:0]   cpu_id;
  logic [ADDR_W-1:0] cpu_vec;
  logic              cpu_ack;
  logic              cpu_eoi;
  logic [NUM_CH-1:0] pending_o;

  modport master (
    output irq_in, cfg_we, cfg_sel, cfg_wdata, cpu_ack, cpu_eoi,
    input  cpu_irq, cpu_id, cpu_vec, pending_o
  );

  modport slave (
    input  irq_in, cfg_we, cfg_sel, cfg_wdata, cpu_ack, cpu_eoi,
    output cpu_irq, cpu_id, cpu_vec, pending_o
  );

endinterface

// File: rtl/intr_prio_arb.sv
// Combinational priority pick: first requesting channel at or after start_i, wrapping.
module intr_prio_arb
  import intr_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned ID_W   = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [ID_W-1:0]   start_i,
  output logic              valid_o_c,
  output logic [ID_W-1:0]   win_id_o_c
);

  int unsigned idx;

  always_comb begin
    valid_o_c  = 1'b0;
    win_id_o_c = '0;
    idx        = 0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      idx = 32'(start_i) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!valid_o_c && req_i[ID_W'(idx)]) begin
        valid_o_c  = 1'b1;
        win_id_o_c = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: latch, mask, arbitrate, one request in flight.
// Define INTR_CTRL_ROUND_ROBIN_EN for rotating priority; default is fixed (ch 0 highest).
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 8,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0180,
  parameter int unsigned       VEC_STRIDE = 8
) (
  input  logic        clk,
  input  logic        reset,
  intr_ctrl_if.slave  bus
);

  localparam int unsigned ID_W = id_width(NUM_CH);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] prev_q;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              irq_q, irq_d;
  logic              ack_fire;
  logic [NUM_CH-1:0] clr_vec;
  logic [NUM_CH-1:0] req_vec;
  logic [ID_W-1:0]   start_ptr;
  logic              arb_valid;
  logic [ID_W-1:0]   arb_id;

  assign req_vec = pend_q & ~mask_q;

  intr_prio_arb #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_arb (
    .req_i      (req_vec),
    .start_i    (start_ptr),
    .valid_o_c  (arb_valid),
    .win_id_o_c (arb_id)
  );

`ifdef INTR_CTRL_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_q, rr_d;

  // Search restarts just past the last acknowledged channel.
  always_comb begin
    rr_d = rr_q;
    if (ack_fire) rr_d = (32'(id_q) == NUM_CH - 1) ? '0 : id_q + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign start_ptr = rr_q;
`else
  assign start_ptr = '0;
`endif

  // Config registers plus pending update; a fresh edge beats any clear.
  always_comb begin
    mask_d  = mask_q;
    mode_d  = mode_q;
    clr_vec = '0;
    if (bus.cfg_we) begin
      case (bus.cfg_sel)
        CFG_MASK: mask_d  = bus.cfg_wdata;
        CFG_MODE: mode_d  = bus.cfg_wdata;
        CFG_CLR:  clr_vec = bus.cfg_wdata;
        default:  ;
      endcase
    end
    if (ack_fire) clr_vec = clr_vec | (NUM_CH'(1) << id_q);
    pend_d = (mode_q & ((bus.irq_in & ~prev_q) | (pend_q & ~clr_vec)))
           | (~mode_q & bus.irq_in);
  end

  // Request FSM; the winner is frozen once REQ is entered.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vec_d    = vec_q;
    irq_d    = irq_q;
    ack_fire = 1'b0;
    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (arb_valid) begin
          id_d    = arb_id;
          vec_d   = VEC_BASE + ADDR_W'(arb_id) * ADDR_W'(VEC_STRIDE);
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        irq_d = 1'b1;
        if (bus.cpu_ack) begin
          ack_fire = 1'b1;
          irq_d    = 1'b0;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        irq_d = 1'b0;
        if (bus.cpu_eoi) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '1;
      mode_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      prev_q  <= bus.irq_in;
      id_q    <= id_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.cpu_irq   = irq_q;
  assign bus.cpu_id    = id_q;
  assign bus.cpu_vec   = vec_q;
  assign bus.pending_o = pend_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with an expected-grant scoreboard queue.
module tb_intr_ctrl;
  import intr_pkg::*;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] vec;
  } exp_t;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  exp_t sb[$];

  intr_ctrl_if #(.NUM_CH(8), .ADDR_W(32)) bus ();

  intr_ctrl #(
    .NUM_CH(8), .ADDR_W(32), .VEC_BASE(32'h0000_0180), .VEC_STRIDE(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void expect_grant(input int id);
    sb.push_back('{id: 3'(id), vec: 32'h180 + 32'(id) * 32'd8});
  endfunction

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = 8'h00;
  endtask

  // Wait (bounded) for a request, score it, then ack and EOI.
  task automatic serve(input string tag, input logic [7:0] exp_pend);
    exp_t e;
    for (int i = 0; i < 20 && bus.cpu_irq !== 1'b1; i++) tick();
    chk({tag, "_irq"}, 64'(bus.cpu_irq), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, 64'(bus.cpu_id), 64'(e.id));
      chk({tag, "_vec"}, 64'(bus.cpu_vec), 64'(e.vec));
    end
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    chk({tag, "_irq_drop"}, 64'(bus.cpu_irq), 64'd0);
    chk({tag, "_pend_after_ack"}, 64'(bus.pending_o), 64'(exp_pend));
    bus.cpu_eoi = 1'b1;
    tick();
    bus.cpu_eoi = 1'b0;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    reset         = 1'b1;
    bus.irq_in    = 8'h00;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = 2'd0;
    bus.cfg_wdata = 8'h00;
    bus.cpu_ack   = 1'b0;
    bus.cpu_eoi   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_irq", 64'(bus.cpu_irq), 64'd0);
    chk("rst_id", 64'(bus.cpu_id), 64'd0);
    chk("rst_vec", 64'(bus.cpu_vec), 64'h180);
    chk("rst_pend", 64'(bus.pending_o), 64'h0);

    // Mask resets to all-ones: a level line latches but is not requested.
    bus.irq_in = 8'h80;
    tick();
    tick();
    chk("rst_mask_pend", 64'(bus.pending_o), 64'h80);
    chk("rst_mask_irq", 64'(bus.cpu_irq), 64'd0);
    bus.irq_in = 8'h00;
    tick();
    cfg_write(CFG_MODE, 8'h77);
    cfg_write(CFG_MASK, 8'h00);

    // Single edge on ch 0: pending at N+1, request at N+2.
    expect_grant(0);
    bus.irq_in = 8'h01;
    tick();
    bus.irq_in = 8'h00;
    chk("t1_pend", 64'(bus.pending_o), 64'h01);
    chk("t1_irq_early", 64'(bus.cpu_irq), 64'd0);
    tick();
    chk("t1_irq_n2", 64'(bus.cpu_irq), 64'd1);
    serve("t1", 8'h00);

    // Simultaneous edges on ch 2 and 5.
    expect_grant(2);
    expect_grant(5);
    bus.irq_in = 8'h24;
    tick();
    bus.irq_in = 8'h00;
    chk("t2_pend", 64'(bus.pending_o), 64'h24);
    serve("t2a", 8'h20);
    serve("t2b", 8'h00);

    // Masked level ch 3, then unmask, then re-request after EOI.
    cfg_write(CFG_MASK, 8'h08);
    bus.irq_in = 8'h08;
    tick();
    tick();
    chk("t3_pend_masked", 64'(bus.pending_o), 64'h08);
    chk("t3_irq_masked", 64'(bus.cpu_irq), 64'd0);
    cfg_write(CFG_MASK, 8'h00);
    chk("t3_irq_unmask0", 64'(bus.cpu_irq), 64'd0);
    tick();
    chk("t3_irq_unmask1", 64'(bus.cpu_irq), 64'd1);
    expect_grant(3);
    serve("t3a", 8'h08);
    chk("t3_eoi_gap", 64'(bus.cpu_irq), 64'd0);
    tick();
    chk("t3_rereq", 64'(bus.cpu_irq), 64'd1);
    expect_grant(3);
    bus.irq_in = 8'h00;
    serve("t3b", 8'h00);

    // No preemption and no withdrawal while in REQ.
    expect_grant(4);
    expect_grant(1);
    bus.irq_in = 8'h10;
    tick();
    bus.irq_in = 8'h00;
    tick();
    chk("t4_id4", 64'(bus.cpu_id), 64'd4);
    bus.irq_in = 8'h02;
    tick();
    bus.irq_in = 8'h00;
    tick();
    chk("t4_hold_id", 64'(bus.cpu_id), 64'd4);
    chk("t4_hold_irq", 64'(bus.cpu_irq), 64'd1);
    cfg_write(CFG_MASK, 8'h10);
    chk("t4_mask_irq", 64'(bus.cpu_irq), 64'd1);
    chk("t4_mask_id", 64'(bus.cpu_id), 64'd4);
    cfg_write(CFG_MASK, 8'h00);
    serve("t4a", 8'h02);
    serve("t4b", 8'h00);

    // Edge vs clear on ch 6 (set wins); stray ack/EOI in IDLE ignored.
    cfg_write(CFG_MASK, 8'h40);
    bus.irq_in    = 8'h40;
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = CFG_CLR;
    bus.cfg_wdata = 8'h40;
    tick();
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = 8'h00;
    bus.irq_in    = 8'h00;
    chk("t5_set_wins", 64'(bus.pending_o), 64'h40);
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    chk("t5_idle_ack_pend", 64'(bus.pending_o), 64'h40);
    chk("t5_idle_ack_irq", 64'(bus.cpu_irq), 64'd0);
    bus.cpu_eoi = 1'b1;
    tick();
    bus.cpu_eoi = 1'b0;
    chk("t5_idle_eoi_irq", 64'(bus.cpu_irq), 64'd0);
    cfg_write(CFG_CLR, 8'h40);
    chk("t5_clear", 64'(bus.pending_o), 64'h00);
    cfg_write(CFG_MASK, 8'h00);

    // Two level lines held high: priority policy decides the order.
    cfg_write(CFG_MODE, 8'h74);
    bus.irq_in = 8'h03;
`ifdef INTR_CTRL_ROUND_ROBIN_EN
    expect_grant(0);
    expect_grant(1);
    expect_grant(0);
    expect_grant(1);
    for (int k = 0; k < 4; k++) serve("t6", 8'h03);
`else
    expect_grant(0);
    expect_grant(0);
    expect_grant(0);
    for (int k = 0; k < 3; k++) serve("t6", 8'h03);
`endif

    // Reset mid-request drops everything back to reset values.
    tick();
    chk("t7_pre_irq", 64'(bus.cpu_irq), 64'd1);
    bus.irq_in = 8'h00;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_irq", 64'(bus.cpu_irq), 64'd0);
    chk("t7_id", 64'(bus.cpu_id), 64'd0);
    chk("t7_vec", 64'(bus.cpu_vec), 64'h180);
    chk("t7_pend", 64'(bus.pending_o), 64'h00);
    bus.irq_in = 8'h04;
    tick();
    tick();
    chk("t7_level_pend", 64'(bus.pending_o), 64'h04);
    chk("t7_masked_irq", 64'(bus.cpu_irq), 64'd0);
    bus.irq_in = 8'h00;
    tick();
    chk("t7_level_follow", 64'(bus.pending_o), 64'h00);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised vectored interrupt controller between external/peripheral interrupt lines and the MIPS core's interrupt entry logic. Latches up to NUM_CH requests, each configurable as level or rising-edge, applies a mask, arbitrates one winner, and presents a request/vector to the core with an ack/end-of-interrupt handshake. One interrupt is in flight at a time; no nesting.

## Interface
- NUM_CH, 8, number of interrupt channels (2..32)
- ADDR_W, 32, vector address width
- VEC_BASE, 32'h0000_0180, vector of channel 0
- VEC_STRIDE, 8, byte spacing between channel vectors
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- irq_in  in  NUM_CH  interrupt lines, synchronous to clk
- cfg_we  in  1  config write strobe
- cfg_sel  in  2  0 = mask reg, 1 = mode reg (1 = edge), 2 = pending clear (write-1-to-clear), 3 = ignored
- cfg_wdata  in  NUM_CH  config write data
- cpu_irq  out  1  request to core
- cpu_id  out  clog2(NUM_CH)  winning channel
- cpu_vec  out  ADDR_W  VEC_BASE + cpu_id*VEC_STRIDE
- cpu_ack  in  1  core accepts request
- cpu_eoi  in  1  core finished handler
- pending_o  out  NUM_CH  raw pending bits

## Operation
- Edge channel: rising edge of irq_in (vs registered previous sample) sets pending bit; cleared by ack of that channel or cfg pending-clear.
- Level channel: pending bit = irq_in each cycle; ack/clear have no lasting effect.
- Request vector = pending & ~mask; masked channels still latch pending.
- FSM IDLE: if request vector nonzero, register arbiter winner into cpu_id/cpu_vec, go REQ.
- REQ: cpu_irq = 1; cpu_id/cpu_vec held stable; no preemption by higher-priority arrivals; masking the selected channel does not withdraw. On cpu_ack: clear winner's edge pending bit, go SERVICE.
- SERVICE: cpu_irq = 0; on cpu_eoi go IDLE. Level line still high after EOI re-requests.
- cpu_ack outside REQ and cpu_eoi outside SERVICE are ignored.
- Simultaneous new edge and clear (ack or cfg) on same channel: set wins.
- Default priority fixed: lowest index wins.
- cfg writes take effect next cycle in all states.

## Timing
- Reset: state IDLE, cpu_irq 0, cpu_id 0, cpu_vec VEC_BASE, pending 0, mask all-ones, mode all-zero (level), previous samples 0, RR pointer 0.
- Edge at irq_in cycle N -> pending_o at N+1 -> cpu_irq at N+2.
- cpu_ack sampled at cycle M -> cpu_irq low at M+1.
- cpu_eoi at cycle E -> IDLE at E+1 -> next cpu_irq at E+2 earliest.
- Reset mid-operation: all state returns to reset values next edge; in-flight request dropped.

## Configuration
- INTR_CTRL_ROUND_ROBIN_EN defined: rotating priority; after ack of channel k, search starts at channel k+1 (wrap at NUM_CH-1 -> 0); pointer updates only on ack.
- Not defined: fixed priority, channel 0 highest; no pointer register.

## Structure
- Package intr_pkg: FSM state encoding (IDLE, REQ, SERVICE), cfg_sel constants (CFG_MASK, CFG_MODE, CFG_CLR).
- Sub-module intr_prio_arb: combinational request -> one-hot/index winner, with optional start pointer for round-robin.

## Test plan
- Reset, mask=0, mode=8'h01, pulse irq_in[0] one cycle -> pending_o=8'h01 next cycle, cpu_irq=1 two cycles after, cpu_id=0, cpu_vec=32'h180; ack -> pending_o=0, cpu_irq=0.
- Edges on ch 2 and 5 same cycle, fixed priority -> id 2 (vec 32'h190) served, after EOI id 5 (vec 32'h1A8).
- Ch 3 level high, mask[3]=1 -> pending_o[3]=1, cpu_irq stays 0; unmask -> cpu_irq after 1 cycle; EOI with line still high -> re-request id 3.
- In REQ for id 4, edge on ch 1 -> cpu_id stays 4 until ack; after EOI id 1 served.
- Edge on ch 6 same cycle as cfg clear of bit 6 -> pending_o[6]=1; ack arriving in IDLE -> no state change.
- With INTR_CTRL_ROUND_ROBIN_EN, ch 0 and 1 held level high -> served order 0,1,0,1; without macro -> 0,0,0.
